// File: rtl/regfile_int_mp_if.sv
// Bus bundle for regfile_int_mp: read/write port signals plus the ready flag.
// The master drives addresses, enables and write data; the slave returns read data and rdy.
interface regfile_int_mp_if #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int NREAD = 2
);
  logic [NREAD*AW-1:0]   ra;
  logic [NREAD-1:0]      re;
  logic [NREAD*XLEN-1:0] rd;
  logic                  we;
  logic [AW-1:0]         wa;
  logic [XLEN-1:0]       wd;
  logic                  rdy;

  modport master (output ra, re, we, wa, wd, input rd, rdy);
  modport slave  (input ra, re, we, wa, wd, output rd, rdy);
endinterface

// File: rtl/regfile_int_mp.sv
// Integer register file: one write port, NREAD registered read ports, power-up clear sweep.
// Build option: define REGFILE_FWD_EN to make a same-cycle write visible to a read of that address.
module regfile_int_mp #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  regfile_int_mp_if.slave  bus
);

  localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                     state_q, state_d;
  logic [AW-1:0]              clr_idx_q, clr_idx_d;
  logic                       rdy_q, rdy_d;
  logic [NREAD-1:0][XLEN-1:0] rd_q, rd_d;

  logic [XLEN-1:0] mem [DEPTH];
  logic            mem_we;
  logic [IW-1:0]   mem_wa;
  logic [XLEN-1:0] mem_wd;

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // The clear sweep and normal writes share the single memory write port.
  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    rdy_d     = rdy_q;
    mem_we    = 1'b0;
    mem_wa    = IW'(bus.wa);
    mem_wd    = bus.wd;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_wa    = IW'(clr_idx_q);
        mem_wd    = '0;
        clr_idx_d = clr_idx_q + AW'(1);
        if (clr_idx_q == LAST) begin
          state_d = RUN;
          rdy_d   = 1'b1;
        end
      end
      RUN: mem_we = bus.we && in_range(bus.wa) && !is_zero_reg(bus.wa);
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NREAD; i++) begin
      logic [AW-1:0] a;
      a       = bus.ra[i*AW +: AW];
      rd_d[i] = rd_q[i];
      if (state_q == RUN && bus.re[i]) begin
        if (is_zero_reg(a) || !in_range(a)) begin
          rd_d[i] = '0;
        end else if (bus.we && bus.wa == a) begin
`ifdef REGFILE_FWD_EN
          rd_d[i] = bus.wd;
`else
          rd_d[i] = mem[IW'(a)];
`endif
        end else begin
          rd_d[i] = mem[IW'(a)];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      rdy_q     <= 1'b0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      rdy_q     <= rdy_d;
      rd_q      <= rd_d;
    end
  end

  // NOTE: the array has no reset so it maps onto RAM; the CLEAR sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  assign bus.rd  = rd_q;
  assign bus.rdy = rdy_q;

endmodule

// File: tb/tb_regfile_int_mp.sv
// Self-checking bench: two instances (DEPTH=32 with zero register, DEPTH=24 without) share stimulus;
// a reference model pushes expected rd/rdy per cycle to a queue that is popped after each edge.
module tb_regfile_int_mp;
  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int NREAD = 2;
`ifdef REGFILE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [NREAD*AW-1:0]   ra;
  logic [NREAD-1:0]      re;
  logic                  we;
  logic [AW-1:0]         wa;
  logic [XLEN-1:0]       wd;

  regfile_int_mp_if #(.XLEN(XLEN), .AW(AW), .NREAD(NREAD)) bus_a ();
  regfile_int_mp_if #(.XLEN(XLEN), .AW(AW), .NREAD(NREAD)) bus_b ();

  assign bus_a.ra = ra;  assign bus_a.re = re;  assign bus_a.we = we;
  assign bus_a.wa = wa;  assign bus_a.wd = wd;
  assign bus_b.ra = ra;  assign bus_b.re = re;  assign bus_b.we = we;
  assign bus_b.wa = wa;  assign bus_b.wd = wd;

  regfile_int_mp #(.XLEN(XLEN), .DEPTH(32), .AW(AW), .NREAD(NREAD), .ZERO_REG(1))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  regfile_int_mp #(.XLEN(XLEN), .DEPTH(24), .AW(AW), .NREAD(NREAD), .ZERO_REG(0))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  typedef struct {
    int              dut;
    int              port;  // -1 selects rdy
    logic [XLEN-1:0] val;
  } exp_t;

  exp_t  sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  string phase    = "init";

  int              depth_m [2] = '{32, 24};
  bit              zero_m  [2] = '{1'b1, 1'b0};
  logic [XLEN-1:0] mem_m   [2][32];
  logic [XLEN-1:0] rd_m    [2][NREAD];
  bit              run_m   [2];
  bit              rdy_m   [2];
  int              clr_m   [2];

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        run_m[d] = 1'b0;
        rdy_m[d] = 1'b0;
        clr_m[d] = 0;
        for (int p = 0; p < NREAD; p++) rd_m[d][p] = '0;
      end else if (!run_m[d]) begin
        mem_m[d][clr_m[d]] = '0;
        if (clr_m[d] == depth_m[d] - 1) begin
          run_m[d] = 1'b1;
          rdy_m[d] = 1'b1;
        end
        clr_m[d]++;
      end else begin
        for (int p = 0; p < NREAD; p++) begin
          int a;
          a = int'(ra[p*AW +: AW]);
          if (re[p]) begin
            if (zero_m[d] && a == 0)           rd_m[d][p] = '0;
            else if (a >= depth_m[d])          rd_m[d][p] = '0;
            else if (we && int'(wa) == a && FWD) rd_m[d][p] = wd;
            else                               rd_m[d][p] = mem_m[d][a];
          end
        end
        if (we && int'(wa) < depth_m[d] && !(zero_m[d] && wa == '0))
          mem_m[d][int'(wa)] = wd;
      end
      for (int p = 0; p < NREAD; p++) sb.push_back('{d, p, rd_m[d][p]});
      sb.push_back('{d, -1, {{(XLEN-1){1'b0}}, rdy_m[d]}});
    end
  endtask

  task automatic step(input bit r, input bit we_i, input logic [AW-1:0] wa_i,
                      input logic [XLEN-1:0] wd_i, input logic [NREAD-1:0] re_i,
                      input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    @(negedge clk);
    rst = r;  we = we_i;  wa = wa_i;  wd = wd_i;  re = re_i;  ra = {ra1, ra0};
    model_step();
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      exp_t e;
      logic [XLEN-1:0] obs;
      e = sb.pop_front();
      if (e.port < 0) obs = {{(XLEN-1){1'b0}}, (e.dut == 0) ? bus_a.rdy : bus_b.rdy};
      else            obs = (e.dut == 0) ? bus_a.rd[e.port*XLEN +: XLEN]
                                         : bus_b.rd[e.port*XLEN +: XLEN];
      check($sformatf("%s_dut%0d_%s", phase, e.dut,
                      (e.port < 0) ? "rdy" : $sformatf("rd%0d", e.port)), obs, e.val);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, '0, '0, '0, '0);
  endtask

  initial begin
    rst = 1'b1;  we = 1'b0;  wa = '0;  wd = '0;  re = '0;  ra = '0;

    // Reset, then a clear sweep with garbage on the inputs that must be ignored.
    phase = "reset";
    step(1'b1, 1'b0, '0, '0, '0, '0, '0);
    phase = "clear";
    for (int k = 0; k < 32; k++)
      step(1'b0, 1'b1, AW'($urandom), $urandom, 2'b11, AW'($urandom), AW'($urandom));
    idle(1);

    phase = "cleared";
    for (int k = 1; k < 32; k++) step(1'b0, 1'b0, '0, '0, 2'b11, AW'(k), AW'(32 - k));

    phase = "basic";
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 2'b00, '0, '0);
    step(1'b0, 1'b0, '0, '0, 2'b11, 5'd5, 5'd5);

    phase = "zero";
    step(1'b0, 1'b1, 5'd0, 32'h1234, 2'b00, '0, '0);
    step(1'b0, 1'b0, '0, '0, 2'b11, 5'd0, 5'd0);

    phase = "collide";
    step(1'b0, 1'b1, 5'd7, 32'h11, 2'b00, '0, '0);
    step(1'b0, 1'b1, 5'd7, 32'h22, 2'b01, 5'd7, 5'd0);
    step(1'b0, 1'b0, '0, '0, 2'b11, 5'd7, 5'd7);

    phase = "hold";
    step(1'b0, 1'b0, '0, '0, 2'b11, 5'd5, 5'd7);
    for (int k = 0; k < 5; k++)
      step(1'b0, 1'b1, AW'(k + 10), 32'hA000 + k, 2'b01, AW'(k + 9), AW'(k + 10));

    phase = "range";
    step(1'b0, 1'b1, 5'd30, 32'hCAFE0030, 2'b00, '0, '0);
    step(1'b0, 1'b0, '0, '0, 2'b11, 5'd30, 5'd23);
    step(1'b0, 1'b1, 5'd31, 32'hCAFE0031, 2'b11, 5'd31, 5'd30);

    phase = "random";
    for (int k = 0; k < 150; k++)
      step(1'b0, 1'($urandom), AW'($urandom), $urandom, NREAD'($urandom),
           AW'($urandom), AW'($urandom));

    phase = "rst_run";
    for (int k = 1; k < 8; k++) step(1'b0, 1'b1, AW'(k), 32'h5000 + k, 2'b11, AW'(k), AW'(k));
    step(1'b1, 1'b1, 5'd3, 32'hFFFF, 2'b11, 5'd1, 5'd2);
    idle(10);
    phase = "rst_clear";
    step(1'b1, 1'b0, '0, '0, 2'b11, 5'd1, 5'd2);
    for (int k = 0; k < 32; k++)
      step(1'b0, 1'b1, AW'($urandom), $urandom, 2'b11, AW'($urandom), AW'($urandom));
    idle(1);
    phase = "after_rst";
    for (int k = 1; k < 8; k++) step(1'b0, 1'b0, '0, '0, 2'b11, AW'(k), AW'(k + 20));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
